// File: rtl/sign_pkg.sv
// Shared constants and helpers for the sign extension / narrowing datapaths.
// Pure functions; no latency, no handshakes.
// Used by both sign_extender and sign_narrower users.
package sign_pkg;

    localparam int SIGN_DATA_WIDTH   = 16;
    localparam int SIGN_DATA_2_WIDTH = 4;

    // Most negative value of an nw-bit two's-complement field (1 followed by 0s).
    function automatic logic [63:0] narrow_min(input int nw);
        return 64'(1) << (nw - 1);
    endfunction

    // Most positive value of an nw-bit two's-complement field (0 followed by 1s).
    function automatic logic [63:0] narrow_max(input int nw);
        return (64'(1) << (nw - 1)) - 64'(1);
    endfunction

    // A ww-bit word fits in nw bits when bits [ww-1:nw-1] are all copies of one value.
    function automatic logic fits_narrow(input logic [63:0] v, input int ww, input int nw);
        logic all0;
        logic all1;
        all0 = 1'b1;
        all1 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i >= nw - 1 && i < ww) begin
                all0 = all0 & ~v[i];
                all1 = all1 & v[i];
            end
        end
        return all0 | all1;
    endfunction

endpackage

// File: rtl/sign_narrower_narrow_check.sv
// Fit check plus saturate/truncate selection for one wide word.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns all handshaking.
module narrow_check
    import sign_pkg::*;
#(
    parameter int DATA_WIDTH   = SIGN_DATA_WIDTH,
    parameter int DATA_2_WIDTH = SIGN_DATA_2_WIDTH,
    parameter bit SATURATE     = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_2_WIDTH-1:0] data_out,
    output logic                    ovf
);

    localparam logic [DATA_2_WIDTH-1:0] FIELD_MIN = DATA_2_WIDTH'(narrow_min(DATA_2_WIDTH));
    localparam logic [DATA_2_WIDTH-1:0] FIELD_MAX = DATA_2_WIDTH'(narrow_max(DATA_2_WIDTH));

    logic fits;

    always_comb begin
        fits     = fits_narrow(64'(data_in), DATA_WIDTH, DATA_2_WIDTH);
        ovf      = ~fits;
        data_out = data_in[DATA_2_WIDTH-1:0];
        if (!fits && SATURATE) begin
            data_out = data_in[DATA_WIDTH-1] ? FIELD_MIN : FIELD_MAX;
        end
    end

endmodule

// File: rtl/sign_narrower.sv
// Narrows a wide two's-complement word to an immediate field, flags/saturates overflow, counts events.
// Latency: 2 cycles (S1 input register, S2 result register); 1 word/cycle when unstalled.
// Backpressure: valid/ready both sides; in_ready = !s1_vld | s1 moving, combinational from out_ready.
module sign_narrower
    import sign_pkg::*;
#(
    parameter int DATA_WIDTH   = SIGN_DATA_WIDTH,
    parameter int DATA_2_WIDTH = SIGN_DATA_2_WIDTH,
    parameter bit SATURATE     = 1'b1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_2_WIDTH-1:0] data_out,
    output logic                    out_ovf,
    output logic                    ovf_sticky,
    output logic [CNT_WIDTH-1:0]    ovf_count,
    input  logic                    clr_count
);

    logic                    s1_vld;
    logic [DATA_WIDTH-1:0]   s1_dat;
    logic                    s2_vld;
    logic [DATA_2_WIDTH-1:0] s2_dat;
    logic                    s2_ovf;

    logic [DATA_2_WIDTH-1:0] nc_dat;
    logic                    nc_ovf;

    logic s1_load;
    logic s2_load;
    logic s2_fire;
    logic ovf_evt;

    narrow_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DATA_2_WIDTH (DATA_2_WIDTH),
        .SATURATE     (SATURATE)
    ) u_narrow_check (
        .data_in  (s1_dat),
        .data_out (nc_dat),
        .ovf      (nc_ovf)
    );

    always_comb begin
        s2_fire  = s2_vld & out_ready;
        s2_load  = s1_vld & (~s2_vld | out_ready);
        in_ready = ~s1_vld | s2_load;
        s1_load  = in_valid & in_ready;
        ovf_evt  = s2_fire & s2_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s2_vld <= 1'b0;
            s2_dat <= '0;
            s2_ovf <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_vld <= 1'b1;
                s1_dat <= data_in;
            end else if (s2_load) begin
                s1_vld <= 1'b0;
            end
            if (s2_load) begin
                s2_vld <= 1'b1;
                s2_dat <= nc_dat;
                s2_ovf <= nc_ovf;
            end else if (s2_fire) begin
                s2_vld <= 1'b0;
            end
        end
    end

    // A counted delivery in the same cycle as a clear restarts history at one event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (ovf_evt) begin
            ovf_sticky <= 1'b1;
            if (clr_count) begin
                ovf_count <= CNT_WIDTH'(1);
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + CNT_WIDTH'(1);
            end
        end else if (clr_count) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end
    end

    assign out_valid = s2_vld;
    assign data_out  = s2_dat;
    assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_sign_narrower.sv
// Randomized and directed checks of sign_narrower (saturating and truncating builds side by side)
// against an arithmetic reference model and an in-order scoreboard.
module tb_sign_narrower;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic          out_ready;
    logic          clr_count;

    logic          in_ready_s, out_valid_s, ovf_s, sticky_s;
    logic [NW-1:0] dout_s;
    logic [CW-1:0] cnt_s;
    logic          in_ready_t, out_valid_t, ovf_t, sticky_t;
    logic [NW-1:0] dout_t;
    logic [CW-1:0] cnt_t;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    int            cnt_m;
    bit            stk_m;
    bit            acc;
    bit            dlv;
    int            ndlv;
    logic [NW-1:0] last_s, last_t;
    logic          last_ovf;

    always #5 clk = ~clk;

    sign_narrower #(.DATA_WIDTH(DW), .DATA_2_WIDTH(NW), .SATURATE(1'b1), .CNT_WIDTH(CW)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .data_in(data_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .data_out(dout_s), .out_ovf(ovf_s),
        .ovf_sticky(sticky_s), .ovf_count(cnt_s), .clr_count(clr_count)
    );

    sign_narrower #(.DATA_WIDTH(DW), .DATA_2_WIDTH(NW), .SATURATE(1'b0), .CNT_WIDTH(CW)) u_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .data_in(data_in),
        .out_valid(out_valid_t), .out_ready(out_ready), .data_out(dout_t), .out_ovf(ovf_t),
        .ovf_sticky(sticky_t), .ovf_count(cnt_t), .clr_count(clr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_narrow(input logic [DW-1:0] w, input bit sat,
                                       output logic [NW-1:0] d, output logic o);
        int sv;
        sv = int'($signed(w));
        o  = (sv < -(1 << (NW - 1))) || (sv > (1 << (NW - 1)) - 1);
        if (!o)       d = NW'(sv);
        else if (sat) d = (sv < 0) ? NW'(1 << (NW - 1)) : NW'((1 << (NW - 1)) - 1);
        else          d = NW'(sv);
    endfunction

    function automatic bit val_fits(input logic [DW-1:0] w);
        int sv;
        sv = int'($signed(w));
        return (sv >= -(1 << (NW - 1))) && (sv <= (1 << (NW - 1)) - 1);
    endfunction

    // One clock: sample handshakes at negedge, advance model, check counters after the edge.
    task automatic cycle();
        logic [DW-1:0] w;
        logic [NW-1:0] es, et;
        logic          eo, eo2;
        @(negedge clk);
        acc = in_valid & in_ready_s;
        dlv = out_valid_s & out_ready;
        chk("in_ready_match", in_ready_t, in_ready_s);
        chk("out_valid_match", out_valid_t, out_valid_s);
        if (rst_n) begin
            eo = 1'b0;
            if (dlv) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    w = q.pop_front();
                    ref_narrow(w, 1'b1, es, eo);
                    ref_narrow(w, 1'b0, et, eo2);
                    chk("data_sat", dout_s, es);
                    chk("data_trn", dout_t, et);
                    chk("ovf_sat", ovf_s, eo);
                    chk("ovf_trn", ovf_t, eo2);
                    last_s = dout_s; last_t = dout_t; last_ovf = ovf_s;
                    ndlv++;
                end
            end
            if (acc) q.push_back(data_in);
            if (dlv && eo) begin
                cnt_m = clr_count ? 1 : ((cnt_m == (1 << CW) - 1) ? cnt_m : cnt_m + 1);
                stk_m = 1'b1;
            end else if (clr_count) begin
                cnt_m = 0;
                stk_m = 1'b0;
            end
            chk("inflight_le2", q.size() <= 2, 1);
        end else begin
            acc = 1'b0;
            q.delete();
            cnt_m = 0;
            stk_m = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ovf_count", cnt_s, cnt_m);
        chk("sticky", sticky_s, stk_m);
        chk("ovf_count_trn", cnt_t, cnt_m);
    endtask

    task automatic send_one(input logic [DW-1:0] v);
        int n0;
        n0 = ndlv;
        in_valid = 1'b1;
        data_in  = v;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && ndlv == n0; i++) cycle();
        chk("send_one_delivered", ndlv - n0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        chk("drained", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int k, n0, sent;
        logic [DW-1:0] v;
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1; clr_count = 1'b0;
        cnt_m = 0; stk_m = 1'b0; ndlv = 0;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_data_out", dout_s, 0);
        chk("rst_out_ovf", ovf_s, 0);
        chk("rst_in_ready", in_ready_s, 1);
        chk("rst_count", cnt_s, 0);

        // Test 1: -7 with exact two-edge latency
        in_valid = 1'b1; data_in = 16'hFFF9;
        cycle();
        in_valid = 1'b0;
        chk("lat_not_early", out_valid_s, 0);
        cycle();
        chk("lat_valid", out_valid_s, 1);
        chk("lat_data", dout_s, 4'h9);
        chk("lat_ovf", ovf_s, 0);
        cycle();

        // Tests 2/3: saturation and truncation corners
        send_one(16'h0008);
        chk("sat_pos", last_s, 4'h7);
        chk("sat_pos_ovf", last_ovf, 1);
        chk("sat_pos_cnt", cnt_s, 1);
        chk("sat_pos_sticky", sticky_s, 1);
        send_one(16'hFFF7);
        chk("sat_neg", last_s, 4'h8);
        chk("sat_neg_ovf", last_ovf, 1);
        send_one(16'h0123);
        chk("trn_ovf_data", last_t, 4'h3);
        chk("trn_ovf_flag", ovf_t, 1);
        send_one(16'h0007);
        chk("trn_fit_data", last_t, 4'h7);
        chk("trn_fit_sat", last_s, 4'h7);
        chk("trn_fit_ovf", last_ovf, 0);
        send_one(16'hFFF8);
        chk("fit_min", last_s, 4'h8);
        chk("fit_min_ovf", last_ovf, 0);
        drain();

        // Test 4: stall fill, then release
        out_ready = 1'b0; in_valid = 1'b1; k = 1; n0 = ndlv;
        for (int i = 0; i < 4; i++) begin
            data_in = DW'(k);
            cycle();
            if (acc) k++;
        end
        chk("stall_accepted", k - 1, 2);
        chk("stall_in_ready", in_ready_s, 0);
        chk("stall_out_data", dout_s, 4'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !(k > 4 && q.size() == 0); i++) begin
            if (k <= 4) begin in_valid = 1'b1; data_in = DW'(k); end
            else in_valid = 1'b0;
            cycle();
            if (acc) k++;
        end
        chk("stall_all_out", ndlv - n0, 4);
        in_valid = 1'b0;

        // Test 5: counter saturation and clear-vs-event priority
        sent = 0; n0 = ndlv;
        for (int i = 0; i < 400 && ndlv - n0 < 300; i++) begin
            v = DW'($urandom);
            if (val_fits(v)) v = v ^ 16'h4000;
            in_valid = (sent < 300);
            data_in  = v;
            cycle();
            if (acc) sent++;
        end
        drain();
        chk("cnt_saturated", cnt_s, 8'hFF);
        in_valid = 1'b1; data_in = 16'h7FFF;
        cycle();
        in_valid = 1'b0;
        cycle();
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        chk("clr_with_event_cnt", cnt_s, 1);
        chk("clr_with_event_sticky", sticky_s, 1);
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        chk("clr_alone_cnt", cnt_s, 0);
        chk("clr_alone_sticky", sticky_s, 0);

        // Random traffic with random backpressure and occasional clears
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 2))
                0:       data_in = DW'($urandom_range(0, 15)) - 16'd8;
                1:       data_in = DW'($urandom);
                default: data_in = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
            endcase
            cycle();
        end
        clr_count = 1'b0; out_ready = 1'b1;
        drain();

        // Test 6: reset with two words in flight
        out_ready = 1'b0; in_valid = 1'b1;
        data_in = 16'h0100; cycle();
        data_in = 16'h0002; cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst6_out_valid", out_valid_s, 0);
        chk("rst6_count", cnt_s, 0);
        chk("rst6_in_ready", in_ready_s, 1);
        out_ready = 1'b1;
        n0 = ndlv;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rst6_no_stale", out_valid_s, 0);
        end
        chk("rst6_no_delivery", ndlv - n0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
